// File: rtl/dma_bus_ctrl_if.sv
// Shared data-side bus: CPU M-stage port on one side and the DM/timer/interrupt
// address space on the other. The DMA controller sits between them.
interface dma_bus_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic [31:0] bus_addr;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  // Arbiter view: takes CPU requests and drives the shared bus.
  modport slave (
    input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata, bus_rdata,
    output cpu_rdata, bus_addr, bus_byteen, bus_wdata
  );

  // Environment view: CPU plus bus devices.
  modport master (
    output cpu_req, cpu_addr, cpu_byteen, cpu_wdata, bus_rdata,
    input  cpu_rdata, bus_addr, bus_byteen, bus_wdata
  );
endinterface

// File: rtl/dma_bus_ctrl.sv
// Word-copy DMA engine that steals idle cycles on the CPU data bus.
// The CPU always wins; the copy advances only when cpu_req is low.
module dma_bus_ctrl #(
  parameter logic [31:0] BASE = 32'h00007f30
) (
  input  logic          clk,
  input  logic          reset,
  dma_bus_ctrl_if.slave bus,
  output logic          irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR} state_t;

  state_t      state_reg, state_next;
  logic [31:0] src_reg, src_next;
  logic [31:0] dst_reg, dst_next;
  logic [31:0] cnt_reg, cnt_next;
  logic [31:0] data_reg, data_next;
  logic        im_reg, im_next;
  logic        done_reg, done_next;
  logic        irq_reg, irq_next;

  logic        win;
  logic        reg_wr;
  logic        busy;
  logic        gnt;
  logic        done_set;
  logic [1:0]  reg_sel;
  logic [31:0] reg_rdata;

  always_comb begin
    win     = (bus.cpu_addr[31:4] == BASE[31:4]);
    reg_wr  = bus.cpu_req && win && (bus.cpu_byteen != 4'b0000);
    reg_sel = bus.cpu_addr[3:2];
    busy    = (state_reg != ST_IDLE);
    // Reset is gated in so a mid-copy reset cycle never touches the bus.
    gnt     = !bus.cpu_req && busy && !reset;
  end

  always_comb begin
    reg_rdata = 32'h0;
    case (reg_sel)
      2'd0:    reg_rdata = src_reg;
      2'd1:    reg_rdata = dst_reg;
      2'd2:    reg_rdata = cnt_reg;
      default: reg_rdata = {28'h0, 1'b0, done_reg, im_reg, busy};
    endcase
  end

  // Bus mux: CPU pass-through, register window, DMA engine, or idle zeros.
  always_comb begin
    bus.cpu_rdata  = 32'h0;
    bus.bus_addr   = 32'h0;
    bus.bus_byteen = 4'b0000;
    bus.bus_wdata  = 32'h0;
    if (bus.cpu_req) begin
      bus.bus_addr  = bus.cpu_addr;
      bus.bus_wdata = bus.cpu_wdata;
      if (win) begin
        bus.cpu_rdata = reg_rdata;
      end else begin
        bus.bus_byteen = bus.cpu_byteen;
        bus.cpu_rdata  = bus.bus_rdata;
      end
    end else if (!reset) begin
      case (state_reg)
        ST_RD: begin
          bus.bus_addr = {src_reg[31:2], 2'b00};
        end
        ST_WR: begin
          bus.bus_addr   = {dst_reg[31:2], 2'b00};
          bus.bus_byteen = 4'b1111;
          bus.bus_wdata  = data_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    im_next    = im_reg;
    done_next  = done_reg;
    done_set   = 1'b0;

    if (reg_wr) begin
      case (reg_sel)
        2'd0: if (!busy) src_next = bus.cpu_wdata;
        2'd1: if (!busy) dst_next = bus.cpu_wdata;
        2'd2: if (!busy) cnt_next = bus.cpu_wdata;
        default: begin
          im_next = bus.cpu_wdata[1];
          if (bus.cpu_wdata[2]) done_next = 1'b0;
          if (!busy && bus.cpu_wdata[0]) begin
            if (cnt_reg != 32'h0) state_next = ST_RD;
            else                  done_set   = 1'b1;
          end
          if (busy && bus.cpu_wdata[3]) state_next = ST_IDLE;
        end
      endcase
    end

    // A register write implies cpu_req, so gnt is low and an abort never races a transfer.
    if (gnt) begin
      case (state_reg)
        ST_RD: begin
          data_next  = bus.bus_rdata;
          src_next   = src_reg + 32'd4;
          state_next = ST_WR;
        end
        ST_WR: begin
          dst_next = dst_reg + 32'd4;
          cnt_next = cnt_reg - 32'd1;
          if (cnt_reg == 32'd1) begin
            state_next = ST_IDLE;
            done_set   = 1'b1;
          end else begin
            state_next = ST_RD;
          end
        end
        default: ;
      endcase
    end

    // Setting DONE overrides a same-cycle W1C.
    if (done_set) done_next = 1'b1;
    irq_next = done_next & im_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      src_reg   <= 32'h0;
      dst_reg   <= 32'h0;
      cnt_reg   <= 32'h0;
      data_reg  <= 32'h0;
      im_reg    <= 1'b0;
      done_reg  <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      im_reg    <= im_next;
      done_reg  <= done_next;
      irq_reg   <= irq_next;
    end
  end

  assign irq = irq_reg;

endmodule
